// File: rtl/obj_oam_scanner_pkg.sv
// Shared types for the OBJ scanline scanner.
//   NUM_OBJS     : number of OAM entries walked per line
//   scan_state_e : scanner FSM states
//   obj_desc_t   : descriptor handed to the per-pixel OBJ renderer
//   obj_dims_t   : bounding width/height pair
//   obj_size()   : shape/size (and double-size) to bounding box in pixels
package obj_scan_pkg;

    localparam int unsigned NUM_OBJS = 128;

    typedef enum logic [2:0] {
        StIdle,
        StFetch0,
        StEval,
        StFetch2,
        StStall,
        StDone
    } scan_state_e;

    typedef struct packed {
        logic [6:0]  index;
        logic [15:0] attr0;
        logic [15:0] attr1;
        logic [15:0] attr2;
        logic [7:0]  hsize;
        logic [7:0]  vsize;
        logic [7:0]  yoff;
    } obj_desc_t;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] h;
    } obj_dims_t;

    // Shape 3 yields a zero-sized box; visibility masks it separately.
    function automatic obj_dims_t obj_size(input logic [1:0] shape, input logic [1:0] size,
                                           input logic dbl_en);
        obj_dims_t d;
        d = '0;
        case (shape)
            2'd0: begin
                d.w = 8'd8 << size;
                d.h = 8'd8 << size;
            end
            2'd1: begin
                case (size)
                    2'd0:    d = '{w: 8'd16, h: 8'd8};
                    2'd1:    d = '{w: 8'd32, h: 8'd8};
                    2'd2:    d = '{w: 8'd32, h: 8'd16};
                    default: d = '{w: 8'd64, h: 8'd32};
                endcase
            end
            2'd2: begin
                case (size)
                    2'd0:    d = '{w: 8'd8,  h: 8'd16};
                    2'd1:    d = '{w: 8'd8,  h: 8'd32};
                    2'd2:    d = '{w: 8'd16, h: 8'd32};
                    default: d = '{w: 8'd32, h: 8'd64};
                endcase
            end
            default: d = '0;
        endcase
        // Largest doubled box is 128, which still fits in 8 bits.
        if (dbl_en) begin
            d.w = d.w << 1;
            d.h = d.h << 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/obj_oam_scanner_if.sv
// Descriptor stream from the OAM scanner to the OBJ pixel renderer.
//   master : scanner side (drives valid and descriptor fields, samples ready)
//   slave  : renderer side (samples descriptor, drives ready)
// A descriptor transfers on a clock edge where obj_valid and obj_ready are both high.
interface obj_desc_if;

    logic        obj_valid;
    logic        obj_ready;
    logic [6:0]  obj_index;
    logic [15:0] obj_attr0;
    logic [15:0] obj_attr1;
    logic [15:0] obj_attr2;
    logic [7:0]  obj_hsize;
    logic [7:0]  obj_vsize;
    logic [7:0]  obj_yoff;

    modport master (
        output obj_valid, obj_index, obj_attr0, obj_attr1, obj_attr2,
               obj_hsize, obj_vsize, obj_yoff,
        input  obj_ready
    );

    modport slave (
        input  obj_valid, obj_index, obj_attr0, obj_attr1, obj_attr2,
               obj_hsize, obj_vsize, obj_yoff,
        output obj_ready
    );

endinterface

// File: rtl/obj_oam_scanner_fifo.sv
// obj_desc_fifo: DEPTH-entry synchronous descriptor FIFO.
//   clock, reset        : clock, synchronous active-high reset
//   flush               : empties the FIFO (pointers and count)
//   push, push_data     : write port, ignored when full
//   pop, pop_data       : read port, pop_data is the head entry, pop ignored when empty
//   full, empty         : registered occupancy flags
// full is derived from the registered count only, so a same-cycle pop never
// makes room for a same-cycle push.
module obj_desc_fifo
    import obj_scan_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      flush,
    input  logic      push,
    input  obj_desc_t push_data,
    input  logic      pop,
    output obj_desc_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = AddrW + 1;

    obj_desc_t        mem_q [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AddrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule

// File: rtl/obj_oam_scanner.sv
// obj_oam_scanner: per-scanline OAM walk for the OBJ pipeline.
// On start, reads all 128 OAM entries (two words each), decodes shape/size,
// applies the row-visibility rule and queues a descriptor for every sprite
// that intersects the latched row.
//   clock, reset          : clock, synchronous active-high reset
//   start, row            : scan request pulse and scanline (latched on start)
//   oam_rd_en, oam_addr   : OAM word read port; oam_rdata returns one cycle later
//   obj (master)          : descriptor stream, valid/ready
//   busy, done, overflow  : scan in progress, end-of-scan pulse, cap hit
// Optional feature: define OBJ_SCAN_LIMIT_EN to stop the scan after MAX_PER_LINE
// pushes and flag overflow; otherwise overflow is tied low and MAX_PER_LINE unused.
module obj_oam_scanner
    import obj_scan_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_PER_LINE = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        row,
    output logic              oam_rd_en,
    output logic [7:0]        oam_addr,
    input  logic [31:0]       oam_rdata,
    obj_desc_if.master        obj,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam logic [6:0] LastIdx = 7'(NUM_OBJS - 1);

    scan_state_e state_q, state_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  row_q, row_d;
    logic [15:0] attr0_q, attr0_d;
    logic [15:0] attr1_q, attr1_d;
    obj_dims_t   dims_q, dims_d;
    obj_desc_t   desc_q, desc_d;

    logic        fifo_push, fifo_flush, fifo_full, fifo_empty;
    obj_desc_t   fifo_wdata, fifo_rdata, fetch_desc;
    logic        advance;

    // Decode of word {idx,0} as it arrives on oam_rdata during StEval.
    logic [15:0] eval_attr0, eval_attr1;
    obj_dims_t   eval_dims;
    logic [7:0]  eval_upper;
    logic        eval_enabled, eval_vis;

    assign eval_attr0   = oam_rdata[15:0];
    assign eval_attr1   = oam_rdata[31:16];
    assign eval_dims    = obj_size(eval_attr0[15:14], eval_attr1[15:14],
                                   eval_attr0[8] & eval_attr0[9]);
    assign eval_upper   = eval_attr0[7:0] + eval_dims.h;
    // rot=0 with dbl=1 means the entry is disabled.
    assign eval_enabled = (eval_attr0[15:14] != 2'd3) && !(!eval_attr0[8] && eval_attr0[9]);
    // Wrap-aware test shared with the per-pixel units: a box that starts in the
    // upper half and wraps past 255 covers rows below its wrapped end.
    assign eval_vis     = eval_enabled && (row_q < eval_upper) &&
                          ((eval_attr0[7] && !eval_upper[7]) || (eval_attr0[7:0] <= row_q));

    assign fetch_desc = '{
        index: idx_q,
        attr0: attr0_q,
        attr1: attr1_q,
        attr2: oam_rdata[15:0],
        hsize: dims_q.w,
        vsize: dims_q.h,
        yoff:  row_q - attr0_q[7:0]
    };

`ifdef OBJ_SCAN_LIMIT_EN
    localparam int unsigned CntW = $clog2(MAX_PER_LINE + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    assign overflow = overflow_q;
`else
    logic [31:0] unused_max_per_line;
    assign unused_max_per_line = MAX_PER_LINE;
    assign overflow = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        row_d      = row_q;
        attr0_d    = attr0_q;
        attr1_d    = attr1_q;
        dims_d     = dims_q;
        desc_d     = desc_q;
        oam_rd_en  = 1'b0;
        oam_addr   = '0;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        fifo_wdata = fetch_desc;
        advance    = 1'b0;
`ifdef OBJ_SCAN_LIMIT_EN
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    row_d      = row;
                    idx_d      = '0;
                    fifo_flush = 1'b1;
`ifdef OBJ_SCAN_LIMIT_EN
                    cnt_d      = '0;
                    overflow_d = 1'b0;
`endif
                    state_d    = StFetch0;
                end
            end
            StFetch0: begin
                oam_rd_en = 1'b1;
                oam_addr  = {idx_q, 1'b0};
                state_d   = StEval;
            end
            StEval: begin
                attr0_d = eval_attr0;
                attr1_d = eval_attr1;
                dims_d  = eval_dims;
                if (eval_vis) begin
                    oam_rd_en = 1'b1;
                    oam_addr  = {idx_q, 1'b1};
                    state_d   = StFetch2;
                end else if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 7'd1;
                    state_d = StFetch0;
                end
            end
            StFetch2: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    advance   = 1'b1;
                end else begin
                    // attr2 is only on oam_rdata this cycle, so capture the whole descriptor.
                    desc_d  = fetch_desc;
                    state_d = StStall;
                end
            end
            StStall: begin
                fifo_wdata = desc_q;
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    advance   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            if (idx_q == LastIdx) begin
                state_d = StDone;
            end else begin
                idx_d   = idx_q + 7'd1;
                state_d = StFetch0;
            end
`ifdef OBJ_SCAN_LIMIT_EN
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(MAX_PER_LINE - 1)) begin
                overflow_d = 1'b1;
                state_d    = StDone;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            row_q      <= '0;
            attr0_q    <= '0;
            attr1_q    <= '0;
            dims_q     <= '0;
            desc_q     <= '0;
`ifdef OBJ_SCAN_LIMIT_EN
            cnt_q      <= '0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            attr0_q    <= attr0_d;
            attr1_q    <= attr1_d;
            dims_q     <= dims_d;
            desc_q     <= desc_d;
`ifdef OBJ_SCAN_LIMIT_EN
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    obj_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (obj.obj_ready),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign obj.obj_valid = ~fifo_empty;
    assign obj.obj_index = fifo_rdata.index;
    assign obj.obj_attr0 = fifo_rdata.attr0;
    assign obj.obj_attr1 = fifo_rdata.attr1;
    assign obj.obj_attr2 = fifo_rdata.attr2;
    assign obj.obj_hsize = fifo_rdata.hsize;
    assign obj.obj_vsize = fifo_rdata.vsize;
    assign obj.obj_yoff  = fifo_rdata.yoff;

endmodule

// File: tb/tb_obj_oam_scanner.sv
// Bench for obj_oam_scanner: directed and randomized scans checked against a
// behavioural OAM-visibility model. Honours OBJ_SCAN_LIMIT_EN (cap of 2).
module tb_obj_oam_scanner;
    import obj_scan_pkg::*;

    localparam int unsigned Depth = 4;
`ifdef OBJ_SCAN_LIMIT_EN
    localparam int unsigned MaxPerLine = 2;
`else
    localparam int unsigned MaxPerLine = 32;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  row = 8'd0;
    logic        oam_rd_en;
    logic [7:0]  oam_addr;
    logic [31:0] oam_rdata = 32'd0;
    logic        busy, done, overflow;
    logic [31:0] oam_mem [256];

    int total = 0;
    int passed = 0;

    always #5 clock = ~clock;

    obj_desc_if obj ();

    obj_oam_scanner #(
        .DEPTH        (Depth),
        .MAX_PER_LINE (MaxPerLine)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .row       (row),
        .oam_rd_en (oam_rd_en),
        .oam_addr  (oam_addr),
        .oam_rdata (oam_rdata),
        .obj       (obj),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // OAM memory: one-cycle read latency
    always @(posedge clock) if (oam_rd_en) oam_rdata <= oam_mem[oam_addr];

    // ---------------- reference model ----------------
    obj_desc_t exp_q[$];
    int        exp_cycle;
    bit        exp_ovf;

    function automatic void build_expected(input logic [7:0] r);
        int w_tab[12] = '{8, 16, 32, 64, 16, 32, 32, 64, 8, 8, 16, 32};
        int h_tab[12] = '{8, 16, 32, 64, 8, 8, 16, 32, 16, 32, 32, 64};
        logic [15:0] a0, a1, a2;
        int shape, size, w, h, y, upper, rr;
        bit vis;
        obj_desc_t d;
        exp_q.delete();
        exp_ovf = 0;
        rr = int'(r);
        for (int i = 0; i < 128; i++) begin
            a0 = oam_mem[2*i][15:0];
            a1 = oam_mem[2*i][31:16];
            a2 = oam_mem[2*i+1][15:0];
            shape = int'(a0[15:14]);
            size  = int'(a1[15:14]);
            if (shape == 3 || (a0[8] == 1'b0 && a0[9] == 1'b1)) continue;
            w = w_tab[shape*4 + size];
            h = h_tab[shape*4 + size];
            if (a0[8] && a0[9]) begin
                w = w * 2;
                h = h * 2;
            end
            y = int'(a0[7:0]);
            upper = (y + h) % 256;
            vis = (rr < upper) && ((y >= 128 && upper < 128) || y <= rr);
            if (vis) begin
                d.index = 7'(i);
                d.attr0 = a0;
                d.attr1 = a1;
                d.attr2 = a2;
                d.hsize = 8'(w);
                d.vsize = 8'(h);
                d.yoff  = 8'((rr - y + 256) % 256);
                exp_q.push_back(d);
`ifdef OBJ_SCAN_LIMIT_EN
                if (exp_q.size() == int'(MaxPerLine)) begin
                    exp_ovf = 1;
                    exp_cycle = 2*i + int'(MaxPerLine) + 3;
                    break;
                end
`endif
            end
        end
        if (!exp_ovf) exp_cycle = 257 + exp_q.size();
    endfunction

    // ---------------- OAM setup ----------------
    task automatic set_entry(input int i, input logic [15:0] a0, input logic [15:0] a1,
                             input logic [15:0] a2);
        oam_mem[2*i]   = {a1, a0};
        oam_mem[2*i+1] = {16'($urandom), a2};
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 128; i++) set_entry(i, 16'h0200, 16'($urandom), 16'($urandom));
    endtask

    task automatic randomize_oam(input logic [7:0] r);
        logic [15:0] a0;
        for (int i = 0; i < 128; i++) begin
            a0 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a0[7:0] = r - 8'($urandom_range(0, 40));
            set_entry(i, a0, 16'($urandom), 16'($urandom));
        end
    endtask

    // ---------------- scan driver / collector ----------------
    obj_desc_t got_q[$];
    int        got_cycle;
    bit        got_timeout, busy_gap;
    logic      ovf_at_done, done_next, busy_next;
    logic      snap_taken, snap_busy, snap_valid, snap_rd_en;
    logic [6:0] snap_index;

    // mode 0: ready high; 1: random ready; 2: ready low through cycle 'hold'
    task automatic run_scan(input logic [7:0] r, input int mode, input int hold,
                            input int restart_at);
        int c;
        bit fin;
        got_q.delete();
        got_cycle = 0; got_timeout = 0; busy_gap = 0; ovf_at_done = 1'bx;
        snap_taken = 0; snap_busy = 0; snap_valid = 0; snap_rd_en = 0; snap_index = 0;
        @(posedge clock); #1;
        start = 1'b1; row = r; obj.obj_ready = (mode == 0);
        @(posedge clock); #1;
        start = 1'b0; row = 8'($urandom);
        if (mode == 1) obj.obj_ready = 1'($urandom_range(0, 1));
        c = 1; fin = 0;
        while (!fin) begin
            @(negedge clock);
            if (obj.obj_valid && obj.obj_ready)
                got_q.push_back('{index: obj.obj_index, attr0: obj.obj_attr0,
                                  attr1: obj.obj_attr1, attr2: obj.obj_attr2,
                                  hsize: obj.obj_hsize, vsize: obj.obj_vsize,
                                  yoff: obj.obj_yoff});
            if (!busy) busy_gap = 1;
            if (mode == 2 && c == hold) begin
                snap_taken = 1; snap_busy = busy; snap_valid = obj.obj_valid;
                snap_rd_en = oam_rd_en; snap_index = obj.obj_index;
            end
            if (done) begin
                got_cycle = c; ovf_at_done = overflow; fin = 1;
            end else if (c >= 3000) begin
                got_timeout = 1; fin = 1;
            end else begin
                @(posedge clock); #1;
                c++;
                start = (c == restart_at);
                case (mode)
                    0: obj.obj_ready = 1'b1;
                    1: obj.obj_ready = 1'($urandom_range(0, 1));
                    default: obj.obj_ready = (c > hold);
                endcase
            end
        end
        for (int n = 0; n < 16; n++) begin
            @(posedge clock); #1;
            start = 1'b0; obj.obj_ready = 1'b1;
            @(negedge clock);
            if (n == 0) begin done_next = done; busy_next = busy; end
            if (!obj.obj_valid) break;
            got_q.push_back('{index: obj.obj_index, attr0: obj.obj_attr0,
                              attr1: obj.obj_attr1, attr2: obj.obj_attr2,
                              hsize: obj.obj_hsize, vsize: obj.obj_vsize,
                              yoff: obj.obj_yoff});
        end
        @(posedge clock); #1;
        obj.obj_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_oam();
        reset = 1'b1; obj.obj_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (oam_rd_en !== 1'b0 || oam_addr !== 8'd0)
            $display("FAIL reset_oam: got rd_en=%b addr=%h expected 0/00", oam_rd_en, oam_addr);
        else passed++;
        total++; if (obj.obj_valid !== 1'b0)
            $display("FAIL reset_valid: got %b expected 0", obj.obj_valid); else passed++;
        total++;
        if ({obj.obj_index, obj.obj_attr0, obj.obj_attr1, obj.obj_attr2, obj.obj_hsize,
             obj.obj_vsize, obj.obj_yoff} !== 79'd0)
            $display("FAIL reset_desc: got idx=%h a0=%h expected all 0",
                     obj.obj_index, obj.obj_attr0);
        else passed++;
        total++; if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset_status: got busy=%b done=%b ovf=%b expected 000",
                     busy, done, overflow);
        else passed++;
        @(posedge clock); #1; reset = 1'b0;
        // reset in the middle of a scan with the FIFO holding entries
        for (int i = 1; i <= 6; i++) set_entry(i, 16'h0000, 16'h0000, 16'(i));
        @(posedge clock); #1; start = 1'b1; row = 8'd2;
        @(posedge clock); #1; start = 1'b0;
        repeat (30) @(posedge clock);
        #1; reset = 1'b1;
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b0 || obj.obj_valid !== 1'b0 || oam_rd_en !== 1'b0)
            $display("FAIL reset_midscan: got busy=%b valid=%b rd_en=%b expected 000",
                     busy, obj.obj_valid, oam_rd_en);
        else passed++;
    endtask

    task automatic test_all_invisible();
        for (int i = 0; i < 128; i++) set_entry(i, 16'h0200, 16'($urandom), 16'($urandom));
        run_scan(8'd0, 0, 0, -1);
        total++; if (got_timeout || got_cycle != 257)
            $display("FAIL invis_latency: got cycle %0d (timeout %0d) expected 257",
                     got_cycle, got_timeout);
        else passed++;
        total++; if (got_q.size() != 0)
            $display("FAIL invis_count: got %0d descriptors expected 0", got_q.size());
        else passed++;
        total++; if (busy_gap || busy_next !== 1'b0 || done_next !== 1'b0)
            $display("FAIL invis_busy: got gap=%0d busy_after=%b done_after=%b expected 0 0 0",
                     busy_gap, busy_next, done_next);
        else passed++;
        total++; if (ovf_at_done !== 1'b0)
            $display("FAIL invis_ovf: got %b expected 0", ovf_at_done); else passed++;
    endtask

    // Single-sprite scenario with constant expectations plus the model cross-check.
    task automatic test_single();
        clear_oam();
        set_entry(5, 16'h0064, 16'h4123, 16'hbeef);
        build_expected(8'd110);
        run_scan(8'd110, 0, 0, -1);
        total++; if (got_q.size() != 1 || exp_q.size() != 1)
            $display("FAIL single_count: got %0d descriptors expected 1", got_q.size());
        else passed++;
        if (got_q.size() == 1) begin
            total++;
            if (got_q[0].index !== 7'd5 || got_q[0].hsize !== 8'd16 ||
                got_q[0].vsize !== 8'd16 || got_q[0].yoff !== 8'd10 ||
                got_q[0].attr2 !== 16'hbeef)
                $display("FAIL single_fields: got %h expected idx 5 16x16 yoff 10", got_q[0]);
            else passed++;
        end
        total++; if (got_cycle != exp_cycle)
            $display("FAIL single_latency: got %0d expected %0d", got_cycle, exp_cycle);
        else passed++;
        run_scan(8'd116, 0, 0, -1);
        total++; if (got_q.size() != 0 || got_cycle != 257)
            $display("FAIL single_below: got %0d descriptors cycle %0d expected 0 and 257",
                     got_q.size(), got_cycle);
        else passed++;
    endtask

    task automatic test_wrap();
        clear_oam();
        set_entry(9, 16'h00fa, 16'h4000, 16'h1234);
        run_scan(8'd5, 0, 0, -1);
        total++; if (got_q.size() != 1)
            $display("FAIL wrap_count: got %0d expected 1", got_q.size());
        else passed++;
        if (got_q.size() == 1) begin
            total++; if (got_q[0].index !== 7'd9 || got_q[0].yoff !== 8'd11)
                $display("FAIL wrap_yoff: got idx %0d yoff %0d expected 9 11",
                         got_q[0].index, got_q[0].yoff);
            else passed++;
        end
        run_scan(8'd10, 0, 0, -1);
        total++; if (got_q.size() != 0)
            $display("FAIL wrap_end: got %0d expected 0", got_q.size()); else passed++;
    endtask

    task automatic test_double();
        clear_oam();
        set_entry(0, 16'h0300, 16'h8000, 16'h0042);
        run_scan(8'd63, 0, 0, -1);
        total++; if (got_q.size() != 1)
            $display("FAIL dbl_count: got %0d expected 1", got_q.size());
        else passed++;
        if (got_q.size() == 1) begin
            total++; if (got_q[0].hsize !== 8'd64 || got_q[0].vsize !== 8'd64 ||
                         got_q[0].yoff !== 8'd63)
                $display("FAIL dbl_size: got %0dx%0d yoff %0d expected 64x64 yoff 63",
                         got_q[0].hsize, got_q[0].vsize, got_q[0].yoff);
            else passed++;
        end
        run_scan(8'd64, 0, 0, -1);
        total++; if (got_q.size() != 0)
            $display("FAIL dbl_edge: got %0d expected 0", got_q.size()); else passed++;
    endtask

    task automatic test_backpressure();
        clear_oam();
        for (int i = 1; i <= 6; i++) set_entry(i, 16'h0000, 16'(i * 3), 16'(16'ha000 + i));
        build_expected(8'd3);
        run_scan(8'd3, 2, 60, -1);
`ifdef OBJ_SCAN_LIMIT_EN
        total++; if (got_cycle != exp_cycle || ovf_at_done !== 1'b1)
            $display("FAIL bp_cap: got cycle %0d ovf %b expected %0d 1",
                     got_cycle, ovf_at_done, exp_cycle);
        else passed++;
`else
        total++;
        if (!snap_taken || snap_busy !== 1'b1 || snap_valid !== 1'b1 ||
            snap_rd_en !== 1'b0 || snap_index !== 7'd1)
            $display("FAIL bp_stall: got taken=%0d busy=%b valid=%b rd=%b idx=%0d expected 1 1 1 0 1",
                     snap_taken, snap_busy, snap_valid, snap_rd_en, snap_index);
        else passed++;
        total++; if (ovf_at_done !== 1'b0)
            $display("FAIL bp_ovf: got %b expected 0", ovf_at_done); else passed++;
`endif
        total++; if (got_timeout || got_q.size() != exp_q.size())
            $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size());
        else passed++;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++; if (got_q[k] !== exp_q[k])
                $display("FAIL bp_desc[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
            else passed++;
        end
    endtask

    // A start pulse mid-scan (with a different row) must not disturb the scan.
    task automatic test_back_to_back();
        logic [7:0] r;
        for (int it = 0; it < 2; it++) begin
            r = 8'($urandom);
            randomize_oam(r);
            build_expected(r);
            run_scan(r, 0, 0, 20);
            total++; if (got_timeout || got_cycle != exp_cycle)
                $display("FAIL b2b_latency: got %0d expected %0d", got_cycle, exp_cycle);
            else passed++;
            total++; if (got_q.size() != exp_q.size())
                $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size());
            else passed++;
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                total++; if (got_q[k] !== exp_q[k])
                    $display("FAIL b2b_desc[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        for (int it = 0; it < 4; it++) begin
            r = 8'($urandom);
            randomize_oam(r);
            build_expected(r);
            run_scan(r, 1, 0, -1);
            total++; if (got_timeout || got_q.size() != exp_q.size())
                $display("FAIL rand_count: got %0d expected %0d (timeout %0d)",
                         got_q.size(), exp_q.size(), got_timeout);
            else passed++;
            for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
                total++; if (got_q[k] !== exp_q[k])
                    $display("FAIL rand_desc[%0d]: got %h expected %h", k, got_q[k], exp_q[k]);
                else passed++;
            end
            total++; if (ovf_at_done !== logic'(exp_ovf))
                $display("FAIL rand_ovf: got %b expected %0d", ovf_at_done, exp_ovf);
            else passed++;
        end
    endtask

    initial begin
        obj.obj_ready = 1'b0;
        test_reset();
        test_all_invisible();
        test_single();
        test_wrap();
        test_double();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
